led_display_row_driver: RTL and testbench

- Downstream neighbour of led_display_pattern_gen: consumes its row/valid/ready/address stream and drives the HUB75 panel pins.
- Each accepted row is shifted out over a divided bit clock while the previous row keeps displaying.
- The panel is then blanked, the new row is latched, the row address is updated and the panel is unblanked.
- One-row input buffer plus a shift register, so the pattern generator can run ahead by one row.

---
 rtl/led_display_package.sv | 46 ++++
 rtl/led_display_bclk_gen.sv | 34 +++
 rtl/led_display_row_driver.sv | 159 +++++++++++++++
 tb/tb_led_display_row_driver.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_display_package.sv
// Shared types for the LED display pipeline: row data layout, HUB75 pin bundle
// and row-driver FSM states.
package led_display_package;

  localparam int unsigned GL_NUM_COL_PIXELS = 64;
  localparam int unsigned GL_COL_IDX_W      = $clog2(GL_NUM_COL_PIXELS);
  localparam int unsigned GL_ROW_ADDR_W     = 4;

  typedef struct packed {
    logic [GL_NUM_COL_PIXELS-1:0] blue;
    logic [GL_NUM_COL_PIXELS-1:0] green;
    logic [GL_NUM_COL_PIXELS-1:0] red;
  } rgb_half_t;

  typedef struct packed {
    rgb_half_t top;
    rgb_half_t bot;
  } rgb_row_t;

  localparam int unsigned GL_RGB_ROW_W = $bits(rgb_row_t);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_WAIT_DISP,
    ST_BLANK,
    ST_LATCH,
    ST_UNBLANK
  } row_drv_state_t;

  typedef struct packed {
    logic                     bclk;
    logic                     lat;
    logic                     oe_n;
    logic [GL_ROW_ADDR_W-1:0] addr;
    logic [2:0]               rgb_top;
    logic [2:0]               rgb_bot;
  } hub75_pins_t;

  // {blue, green, red} of one column, in HUB75 pin order.
  function automatic logic [2:0] pixel_at(input rgb_half_t h,
                                          input logic [GL_COL_IDX_W-1:0] c);
    return {h.blue[c], h.green[c], h.red[c]};
  endfunction

endpackage

// File: rtl/led_display_bclk_gen.sv
// Phase timer for the HUB75 bit clock: H cycles per phase, toggling level.
// Also reused to time the latch pulse. Held in the low phase while disabled.
module led_display_bclk_gen #(
  parameter int unsigned H = 2
) (
  input  logic clk_in,
  input  logic n_reset_in,
  input  logic en,
  output logic phase_hi,
  output logic phase_end
);

  localparam int unsigned CW = (H > 1) ? $clog2(H) : 1;

  logic [CW-1:0] cnt;

  assign phase_end = en && (cnt == CW'(H - 1));

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      cnt      <= '0;
      phase_hi <= 1'b0;
    end else if (!en) begin
      cnt      <= '0;
      phase_hi <= 1'b0;
    end else if (phase_end) begin
      cnt      <= '0;
      phase_hi <= ~phase_hi;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_display_row_driver.sv
// HUB75 row driver: buffers one row, shifts it out on a divided bit clock while
// the previous row stays lit, then blanks, latches, updates address, unblanks.
module led_display_row_driver
  import led_display_package::*;
#(
  parameter int unsigned SYS_CLK_FREQ   = 100_000_000,
  parameter int unsigned BCLK_FREQ      = 21_000_000,
  parameter int unsigned DISPLAY_CYCLES = 2000,
  parameter int unsigned BLANK_CYCLES   = 2,
  parameter bit          SIMULATION     = 1'b0
) (
  input  logic                     clk_in,
  input  logic                     n_reset_in,
  input  rgb_row_t                 row_in,
  input  logic                     row_valid_in,
  output logic                     row_ready_out,
  input  logic [GL_ROW_ADDR_W-1:0] row_address_in,
  output logic                     bclk_out,
  output logic [2:0]               rgb_top_out,
  output logic [2:0]               rgb_bot_out,
  output logic                     lat_out,
  output logic                     oe_n_out,
  output logic [GL_ROW_ADDR_W-1:0] addr_out,
  output logic                     busy_out
);

  localparam int unsigned H_DIV   = SYS_CLK_FREQ / (2 * BCLK_FREQ);
  localparam int unsigned H       = (H_DIV < 1) ? 1 : H_DIV;
  localparam int unsigned DISP_N  = SIMULATION ? 64 : DISPLAY_CYCLES;
  localparam int unsigned TW      = $clog2(DISP_N + 1);
  localparam int unsigned BLANK_N = (BLANK_CYCLES < 1) ? 1 : BLANK_CYCLES;
  localparam int unsigned BW      = (BLANK_N > 1) ? $clog2(BLANK_N) : 1;

  row_drv_state_t           state;
  hub75_pins_t              pins;
  rgb_row_t                 in_row;
  logic [GL_ROW_ADDR_W-1:0] in_addr;
  rgb_row_t                 shift_row;
  logic [GL_ROW_ADDR_W-1:0] pend_addr;
  logic [GL_COL_IDX_W-1:0]  col;
  logic [BW-1:0]            dcnt;
  logic [TW-1:0]            timer;
  logic                     lit;
  logic                     gen_en;
  logic                     phase_hi;
  logic                     phase_end;

  assign gen_en = (state == ST_SHIFT) || (state == ST_LATCH);

  led_display_bclk_gen #(.H(H)) u_bclk_gen (
    .clk_in     (clk_in),
    .n_reset_in (n_reset_in),
    .en         (gen_en),
    .phase_hi   (phase_hi),
    .phase_end  (phase_end)
  );

  assign bclk_out    = pins.bclk;
  assign lat_out     = pins.lat;
  assign oe_n_out    = pins.oe_n;
  assign addr_out    = pins.addr;
  assign rgb_top_out = pins.rgb_top;
  assign rgb_bot_out = pins.rgb_bot;

  // Row payload needs no reset; row_ready_out alone tracks buffer occupancy.
  always_ff @(posedge clk_in) begin
    if (row_valid_in && row_ready_out) begin
      in_row  <= row_in;
      in_addr <= row_address_in;
    end
  end

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      state         <= ST_IDLE;
      pins          <= '{bclk: 1'b0, lat: 1'b0, oe_n: 1'b1, addr: '0,
                         rgb_top: '0, rgb_bot: '0};
      row_ready_out <= 1'b1;
      busy_out      <= 1'b0;
      shift_row     <= '0;
      pend_addr     <= '0;
      col           <= '0;
      dcnt          <= '0;
      timer         <= '0;
      lit           <= 1'b0;
    end else begin
      if (timer != '0) timer <= timer - 1'b1;
      if (row_valid_in && row_ready_out) row_ready_out <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!row_ready_out) begin
            shift_row     <= in_row;
            pend_addr     <= in_addr;
            col           <= GL_COL_IDX_W'(GL_NUM_COL_PIXELS - 1);
            pins.rgb_top  <= pixel_at(in_row.top, GL_COL_IDX_W'(GL_NUM_COL_PIXELS - 1));
            pins.rgb_bot  <= pixel_at(in_row.bot, GL_COL_IDX_W'(GL_NUM_COL_PIXELS - 1));
            row_ready_out <= 1'b1;
            busy_out      <= 1'b1;
            state         <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Next column is presented on the same edge that drops bclk.
          if (phase_end) begin
            if (!phase_hi) begin
              pins.bclk <= 1'b1;
            end else begin
              pins.bclk <= 1'b0;
              if (col == '0) begin
                state <= ST_WAIT_DISP;
              end else begin
                col          <= col - 1'b1;
                pins.rgb_top <= pixel_at(shift_row.top, col - 1'b1);
                pins.rgb_bot <= pixel_at(shift_row.bot, col - 1'b1);
              end
            end
          end
        end
        ST_WAIT_DISP: begin
          if (timer == '0 || !lit) begin
            pins.oe_n <= 1'b1;
            pins.addr <= pend_addr;
            dcnt      <= '0;
            state     <= ST_BLANK;
          end
        end
        ST_BLANK: begin
          if (dcnt == BW'(BLANK_N - 1)) begin
            pins.lat <= 1'b1;
            state    <= ST_LATCH;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        ST_LATCH: begin
          if (phase_end) begin
            pins.lat <= 1'b0;
            dcnt     <= '0;
            state    <= ST_UNBLANK;
          end
        end
        ST_UNBLANK: begin
          if (dcnt == BW'(BLANK_N - 1)) begin
            pins.oe_n <= 1'b0;
            lit       <= 1'b1;
            timer     <= TW'(DISP_N);
            busy_out  <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_display_row_driver.sv
// Randomized bench for led_display_row_driver: a pin-level monitor rebuilds each
// latched row from the bclk samples and checks it against the rows sent.
module tb_led_display_row_driver;
  import led_display_package::*;

  localparam int unsigned HB    = 2;
  localparam int unsigned BLANK = 2;
  localparam int unsigned DISP  = 64;

  logic                     clk_in = 1'b0;
  logic                     n_reset_in;
  rgb_row_t                 row_in;
  logic                     row_valid_in;
  logic                     row_ready_out;
  logic [GL_ROW_ADDR_W-1:0] row_address_in;
  logic                     bclk_out;
  logic [2:0]               rgb_top_out;
  logic [2:0]               rgb_bot_out;
  logic                     lat_out;
  logic                     oe_n_out;
  logic [GL_ROW_ADDR_W-1:0] addr_out;
  logic                     busy_out;

  led_display_row_driver #(
    .SYS_CLK_FREQ   (100_000_000),
    .BCLK_FREQ      (21_000_000),
    .DISPLAY_CYCLES (2000),
    .BLANK_CYCLES   (BLANK),
    .SIMULATION     (1'b1)
  ) dut (
    .clk_in         (clk_in),
    .n_reset_in     (n_reset_in),
    .row_in         (row_in),
    .row_valid_in   (row_valid_in),
    .row_ready_out  (row_ready_out),
    .row_address_in (row_address_in),
    .bclk_out       (bclk_out),
    .rgb_top_out    (rgb_top_out),
    .rgb_bot_out    (rgb_bot_out),
    .lat_out        (lat_out),
    .oe_n_out       (oe_n_out),
    .addr_out       (addr_out),
    .busy_out       (busy_out)
  );

  always #5 clk_in = ~clk_in;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    rgb_row_t                 row;
    logic [GL_ROW_ADDR_W-1:0] addr;
  } xfer_t;

  xfer_t exp_q[$];

  // Pin monitor state
  localparam hub75_pins_t PINS_RST = '{bclk: 1'b0, lat: 1'b0, oe_n: 1'b1, addr: '0,
                                       rgb_top: '0, rgb_bot: '0};
  hub75_pins_t cur, prev = PINS_RST;
  longint      cyc = 0, last_rise = 0, lat_rise_cyc = 0, lat_fall_cyc = 0;
  longint      oe_rise_cyc = 0, oe_fall_cyc = 0;
  bit          have_lit = 0, oe_fall_pending = 0;
  int unsigned edge_cnt = 0, latch_cnt = 0;
  logic [2:0]  cap_top [GL_NUM_COL_PIXELS];
  logic [2:0]  cap_bot [GL_NUM_COL_PIXELS];
  xfer_t       e_x;
  rgb_row_t    got_row;

  task automatic check_latch();
    lat_rise_cyc = cyc;
    latch_cnt++;
    check_val("lat_oe_blank", cur.oe_n, 1);
    check_val("blank_before_lat", (cyc - oe_rise_cyc) >= BLANK, 1);
    if (have_lit) check_val("display_time", (cyc - oe_fall_cyc) >= DISP, 1);
    check_val("bclk_edges", edge_cnt, GL_NUM_COL_PIXELS);
    check_val("lat_expected_row", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e_x = exp_q.pop_front();
      got_row = '0;
      for (int i = 0; i < GL_NUM_COL_PIXELS; i++) begin
        got_row.top.red[63-i]   = cap_top[i][0];
        got_row.top.green[63-i] = cap_top[i][1];
        got_row.top.blue[63-i]  = cap_top[i][2];
        got_row.bot.red[63-i]   = cap_bot[i][0];
        got_row.bot.green[63-i] = cap_bot[i][1];
        got_row.bot.blue[63-i]  = cap_bot[i][2];
      end
      check_val("lat_addr",  cur.addr,            e_x.addr);
      check_val("top_red",   got_row.top.red,     e_x.row.top.red);
      check_val("top_green", got_row.top.green,   e_x.row.top.green);
      check_val("top_blue",  got_row.top.blue,    e_x.row.top.blue);
      check_val("bot_red",   got_row.bot.red,     e_x.row.bot.red);
      check_val("bot_green", got_row.bot.green,   e_x.row.bot.green);
      check_val("bot_blue",  got_row.bot.blue,    e_x.row.bot.blue);
    end
    edge_cnt = 0;
  endtask

  always @(negedge clk_in) begin
    cyc++;
    cur = '{bclk: bclk_out, lat: lat_out, oe_n: oe_n_out, addr: addr_out,
            rgb_top: rgb_top_out, rgb_bot: rgb_bot_out};
    if (!n_reset_in) begin
      edge_cnt        = 0;
      have_lit        = 0;
      oe_fall_pending = 0;
      oe_rise_cyc     = cyc;
      prev            = PINS_RST;
    end else begin
      if (cur.bclk && !prev.bclk) begin
        if (edge_cnt > 0) check_val("bclk_period", cyc - last_rise, 2 * HB);
        if (edge_cnt < GL_NUM_COL_PIXELS) begin
          cap_top[edge_cnt] = cur.rgb_top;
          cap_bot[edge_cnt] = cur.rgb_bot;
        end
        edge_cnt++;
        last_rise = cyc;
      end
      if (cur.oe_n && !prev.oe_n) oe_rise_cyc = cyc;
      if (cur.lat && !prev.lat) check_latch();
      if (!cur.lat && prev.lat) begin
        check_val("lat_width", cyc - lat_rise_cyc, HB);
        lat_fall_cyc    = cyc;
        oe_fall_pending = 1;
      end
      if (!cur.oe_n && prev.oe_n) begin
        check_val("unblank_delay", oe_fall_pending ? (cyc - lat_fall_cyc) : 64'd0, BLANK);
        oe_fall_cyc     = cyc;
        have_lit        = 1;
        oe_fall_pending = 0;
      end
      prev = cur;
    end
  end

  function automatic rgb_row_t rand_row();
    rgb_row_t r;
    r.top.red   = {$urandom, $urandom};
    r.top.green = {$urandom, $urandom};
    r.top.blue  = {$urandom, $urandom};
    r.bot.red   = {$urandom, $urandom};
    r.bot.green = {$urandom, $urandom};
    r.bot.blue  = {$urandom, $urandom};
    return r;
  endfunction

  // Called at a negedge; leaves row_valid_in high for back-to-back use.
  task automatic send_row(input rgb_row_t r, input logic [GL_ROW_ADDR_W-1:0] a);
    int unsigned waited = 0;
    row_in         = r;
    row_address_in = a;
    row_valid_in   = 1'b1;
    while (!row_ready_out && waited < 3000) begin
      @(negedge clk_in);
      waited++;
    end
    check_val("accept_ready", row_ready_out, 1);
    if (row_ready_out) begin
      exp_q.push_back('{row: r, addr: a});
      @(negedge clk_in);
      check_val("ready_drop", row_ready_out, 0);
    end
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while ((exp_q.size() != 0 || busy_out) && n < 20000) begin
      @(negedge clk_in);
      n++;
    end
    check_val("drain_queue", exp_q.size(), 0);
    check_val("drain_busy", busy_out, 0);
  endtask

  task automatic check_reset_pins();
    check_val("rst_bclk",  bclk_out, 0);
    check_val("rst_lat",   lat_out, 0);
    check_val("rst_oe_n",  oe_n_out, 1);
    check_val("rst_addr",  addr_out, 0);
    check_val("rst_rgb",   {rgb_top_out, rgb_bot_out}, 0);
    check_val("rst_ready", row_ready_out, 1);
    check_val("rst_busy",  busy_out, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rgb_row_t    r;
    int unsigned l0, bad, n;

    n_reset_in     = 1'b0;
    row_valid_in   = 1'b0;
    row_in         = '0;
    row_address_in = '0;
    repeat (10) @(negedge clk_in);
    check_reset_pins();
    n_reset_in = 1'b1;
    @(negedge clk_in);

    // Single row: top red solid, address 5
    r = '0;
    r.top.red = '1;
    send_row(r, 4'd5);
    row_valid_in = 1'b0;
    wait_drain();
    check_val("single_addr", addr_out, 5);
    check_val("single_lit", oe_n_out, 0);

    // Column order: bottom green, leftmost column only
    r = '0;
    r.bot.green[63] = 1'b1;
    send_row(r, 4'd9);
    row_valid_in = 1'b0;
    wait_drain();

    // Backpressure: three rows with valid held high
    l0 = latch_cnt;
    for (int unsigned i = 0; i < 3; i++) send_row(rand_row(), 4'(i));
    row_valid_in = 1'b0;
    wait_drain();
    check_val("bp_latches", latch_cnt - l0, 3);

    // Random rows with random idle gaps
    for (int unsigned i = 0; i < 6; i++) begin
      send_row(rand_row(), 4'($urandom_range(0, 15)));
      row_valid_in = 1'b0;
      repeat ($urandom_range(0, 300)) @(negedge clk_in);
    end
    wait_drain();

    // Reset mid-shift with a second row sitting in the buffer
    send_row(rand_row(), 4'd3);
    send_row(rand_row(), 4'd4);
    row_valid_in = 1'b0;
    n = 0;
    while (edge_cnt < 20 && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    check_val("mid_shift_edges", edge_cnt >= 20, 1);
    l0 = latch_cnt;
    n_reset_in = 1'b0;
    exp_q.delete();
    #1;
    check_reset_pins();
    repeat (3) @(negedge clk_in);
    n_reset_in = 1'b1;
    @(negedge clk_in);
    check_val("rst_no_latch", latch_cnt - l0, 0);
    send_row(rand_row(), 4'd7);
    row_valid_in = 1'b0;
    wait_drain();
    check_val("post_rst_latches", latch_cnt - l0, 1);

    // Address wrap: 0..15 then 0, back to back
    l0 = latch_cnt;
    for (int unsigned i = 0; i < 17; i++) send_row(rand_row(), 4'(i % 16));
    row_valid_in = 1'b0;
    wait_drain();
    check_val("wrap_latches", latch_cnt - l0, 17);
    check_val("wrap_final_addr", addr_out, 0);

    // Last row stays lit with no further input
    bad = 0;
    repeat (5000) begin
      @(negedge clk_in);
      if (oe_n_out !== 1'b0 || lat_out !== 1'b0 || addr_out !== 4'd0) bad++;
    end
    check_val("persist", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
